vx_cache_partition_ctrl: RTL and testbench

- Per-socket controller that repartitions each L1 data-cache unit's sets between L1 cache and shared memory at run time, driven by DCR writes.
- Generalises the single fixed-register split to NUM_UNITS independently configured units.
- Adds a safe reconfiguration protocol: drain the unit, flush the L1 sets being surrendered, then apply atomically.
- Sits between the socket DCR bus and the dcache cluster's per-unit set-limit inputs.

---
 rtl/vx_cache_partition_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_vx_cache_partition_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_cache_partition_ctrl.sv
// Per-socket L1/shared-memory set repartitioning controller: each dcache unit is
// drained, flushed of surrendered sets when shrinking, then switched atomically.
module vx_cache_partition_ctrl #(
  parameter int          NUM_UNITS     = 2,
  parameter int          TOTAL_SETS    = 64,
  parameter int          MIN_L1_SETS   = 1,
  parameter int          SET_W         = 12,
  parameter logic [11:0] DCR_BASE      = 12'h00A,
  parameter int          DRAIN_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dcr_wr_valid,
  input  logic [11:0]                dcr_wr_addr,
  input  logic [31:0]                dcr_wr_data,
  output logic [NUM_UNITS-1:0]       drain_req,
  input  logic [NUM_UNITS-1:0]       drain_ack,
  output logic [NUM_UNITS-1:0]       flush_req,
  output logic [NUM_UNITS*SET_W-1:0] flush_lo,
  output logic [NUM_UNITS*SET_W-1:0] flush_hi,
  input  logic [NUM_UNITS-1:0]       flush_done,
  output logic [NUM_UNITS*SET_W-1:0] l1_sets,
  output logic [NUM_UNITS*SET_W-1:0] smem_sets,
  output logic                       cfg_busy,
  output logic [NUM_UNITS-1:0]       cfg_err
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, APPLY} state_t;

  localparam int                CNT_W    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [SET_W-1:0]  TOTAL    = SET_W'(TOTAL_SETS);
  localparam logic [SET_W-1:0]  MAX_REQ  = SET_W'(TOTAL_SETS - MIN_L1_SETS);

  // Requested smem sets are clamped so at least MIN_L1_SETS stay as L1.
  function automatic logic [SET_W-1:0] clamp_target(input logic [SET_W-1:0] req);
    logic [SET_W-1:0] lim;
    lim = (req > MAX_REQ) ? MAX_REQ : req;
    return TOTAL - lim;
  endfunction

  state_t           state_q [NUM_UNITS];
  state_t           state_d [NUM_UNITS];
  logic [SET_W-1:0] pend_q  [NUM_UNITS];
  logic [SET_W-1:0] pend_d  [NUM_UNITS];
  logic [SET_W-1:0] snap_q  [NUM_UNITS];
  logic [SET_W-1:0] snap_d  [NUM_UNITS];
  logic [SET_W-1:0] l1_q    [NUM_UNITS];
  logic [SET_W-1:0] l1_d    [NUM_UNITS];
  logic [SET_W-1:0] smem_q  [NUM_UNITS];
  logic [SET_W-1:0] smem_d  [NUM_UNITS];
  logic [SET_W-1:0] lo_q    [NUM_UNITS];
  logic [SET_W-1:0] lo_d    [NUM_UNITS];
  logic [SET_W-1:0] hi_q    [NUM_UNITS];
  logic [SET_W-1:0] hi_d    [NUM_UNITS];
  logic [CNT_W-1:0] cnt_q   [NUM_UNITS];
  logic [CNT_W-1:0] cnt_d   [NUM_UNITS];

  logic [NUM_UNITS-1:0] drain_q, drain_d;
  logic [NUM_UNITS-1:0] flush_q, flush_d;
  logic [NUM_UNITS-1:0] err_q, err_d;
  logic [NUM_UNITS-1:0] wr_hit;
  logic                 busy_q, busy_d;
  logic [SET_W-1:0]     wr_tgt;
  logic                 unused_wr_data;

  assign wr_tgt         = clamp_target(dcr_wr_data[SET_W-1:0]);
  assign unused_wr_data = ^dcr_wr_data[31:SET_W];

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    assign wr_hit[g]                     = dcr_wr_valid && (dcr_wr_addr == DCR_BASE + 12'(g));
    assign flush_lo[g*SET_W +: SET_W]    = lo_q[g];
    assign flush_hi[g*SET_W +: SET_W]    = hi_q[g];
    assign l1_sets[g*SET_W +: SET_W]     = l1_q[g];
    assign smem_sets[g*SET_W +: SET_W]   = smem_q[g];
  end

  assign drain_req = drain_q;
  assign flush_req = flush_q;
  assign cfg_err   = err_q;
  assign cfg_busy  = busy_q;

  always_comb begin
    busy_d  = 1'b0;
    drain_d = drain_q;
    flush_d = flush_q;
    err_d   = err_q;
    for (int u = 0; u < NUM_UNITS; u++) begin
      state_d[u] = state_q[u];
      pend_d[u]  = pend_q[u];
      snap_d[u]  = snap_q[u];
      l1_d[u]    = l1_q[u];
      smem_d[u]  = smem_q[u];
      lo_d[u]    = lo_q[u];
      hi_d[u]    = hi_q[u];
      cnt_d[u]   = cnt_q[u];

      if (wr_hit[u]) begin
        pend_d[u] = wr_tgt;
        err_d[u]  = 1'b0;
      end

      case (state_q[u])
        IDLE: begin
          // A fresh write or a pending value left over from the last apply both start a drain.
          if (pend_d[u] != l1_q[u]) begin
            state_d[u] = DRAIN;
            drain_d[u] = 1'b1;
            cnt_d[u]   = '0;
          end
        end
        DRAIN: begin
          // Exit decisions use the pending value registered before this cycle's write.
          if (drain_ack[u]) begin
            snap_d[u] = pend_q[u];
            cnt_d[u]  = '0;
            if (pend_q[u] >= l1_q[u]) begin
              state_d[u] = APPLY;
            end else begin
              state_d[u] = FLUSH;
              flush_d[u] = 1'b1;
              lo_d[u]    = pend_q[u];
              hi_d[u]    = l1_q[u];
            end
          end else if (cnt_q[u] == CNT_LAST) begin
            state_d[u] = IDLE;
            drain_d[u] = 1'b0;
            err_d[u]   = 1'b1;
            pend_d[u]  = l1_q[u];
            cnt_d[u]   = '0;
          end else begin
            cnt_d[u] = cnt_q[u] + 1'b1;
          end
        end
        FLUSH: begin
          if (flush_done[u]) begin
            state_d[u] = APPLY;
            flush_d[u] = 1'b0;
          end
        end
        APPLY: begin
          l1_d[u]    = snap_q[u];
          smem_d[u]  = TOTAL - snap_q[u];
          drain_d[u] = 1'b0;
          state_d[u] = IDLE;
        end
        default: state_d[u] = IDLE;
      endcase

      busy_d = busy_d | (state_d[u] != IDLE) | (pend_d[u] != l1_d[u]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        state_q[u] <= IDLE;
        pend_q[u]  <= TOTAL;
        snap_q[u]  <= TOTAL;
        l1_q[u]    <= TOTAL;
        smem_q[u]  <= '0;
        lo_q[u]    <= '0;
        hi_q[u]    <= '0;
        cnt_q[u]   <= '0;
      end
      drain_q <= '0;
      flush_q <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        state_q[u] <= state_d[u];
        pend_q[u]  <= pend_d[u];
        snap_q[u]  <= snap_d[u];
        l1_q[u]    <= l1_d[u];
        smem_q[u]  <= smem_d[u];
        lo_q[u]    <= lo_d[u];
        hi_q[u]    <= hi_d[u];
        cnt_q[u]   <= cnt_d[u];
      end
      drain_q <= drain_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_vx_cache_partition_ctrl.sv
// Bench for vx_cache_partition_ctrl: directed vector table, hand-written corner
// sequences, and a randomized run against a final-configuration model.
module tb_vx_cache_partition_ctrl;
  localparam int          NU   = 2;
  localparam int          TS   = 64;
  localparam int          MINL = 1;
  localparam int          SW   = 12;
  localparam int          TO   = 1024;
  localparam logic [11:0] BASE = 12'h00A;

  logic              clk = 1'b0;
  logic              reset;
  logic              dcr_wr_valid;
  logic [11:0]       dcr_wr_addr;
  logic [31:0]       dcr_wr_data;
  logic [NU-1:0]     drain_req, drain_ack, flush_req, flush_done, cfg_err;
  logic [NU*SW-1:0]  flush_lo, flush_hi, l1_sets, smem_sets;
  logic              cfg_busy;

  always #5 clk = ~clk;

  vx_cache_partition_ctrl #(
    .NUM_UNITS(NU), .TOTAL_SETS(TS), .MIN_L1_SETS(MINL), .SET_W(SW),
    .DCR_BASE(BASE), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .drain_req(drain_req), .drain_ack(drain_ack),
    .flush_req(flush_req), .flush_lo(flush_lo), .flush_hi(flush_hi), .flush_done(flush_done),
    .l1_sets(l1_sets), .smem_sets(smem_sets), .cfg_busy(cfg_busy), .cfg_err(cfg_err)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          unit;
    bit          chg;
    bit          fl;
    int          lo;
    int          hi;
    int          l1;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  int   exp_l1 [NU];
  int   prev_l1 [NU];
  int   dlo [NU];
  int   dhi [NU];
  vec_t vecs [$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int l1_of(input int u);
    return int'(l1_sets[u*SW +: SW]);
  endfunction
  function automatic int smem_of(input int u);
    return int'(smem_sets[u*SW +: SW]);
  endfunction
  function automatic int lo_of(input int u);
    return int'(flush_lo[u*SW +: SW]);
  endfunction
  function automatic int hi_of(input int u);
    return int'(flush_hi[u*SW +: SW]);
  endfunction

  // Reference: L1 sets a unit should end up with after a write of this data word.
  function automatic int model_l1(input logic [31:0] d);
    int r;
    r = int'(d & 32'h0000_0FFF);
    if (r > TS - MINL) r = TS - MINL;
    return TS - r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dcr_write(input logic [11:0] a, input logic [31:0] d);
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = a;
    dcr_wr_data  = d;
    tick();
    dcr_wr_valid = 1'b0;
  endtask

  task automatic pulse_ack(input int u);
    drain_ack[u] = 1'b1;
    tick();
    drain_ack[u] = 1'b0;
  endtask

  task automatic pulse_done(input int u);
    flush_done[u] = 1'b1;
    tick();
    flush_done[u] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int u;
    u = v.unit;
    dcr_write(v.addr, v.data);
    chk("drain_on_write", drain_req, v.chg ? (longint'(1) << u) : 0);
    if (v.chg) begin
      repeat (5) tick();
      chk("drain_held", drain_req[u], 1);
      chk("no_flush_in_drain", flush_req[u], 0);
      pulse_ack(u);
      chk("flush_req", flush_req[u], v.fl);
      if (v.fl) begin
        chk("flush_lo", lo_of(u), v.lo);
        chk("flush_hi", hi_of(u), v.hi);
        repeat (2) tick();
        chk("flush_wait", flush_req[u], 1);
        pulse_done(u);
        chk("flush_drop", flush_req[u], 0);
        chk("drain_in_apply", drain_req[u], 1);
      end
      chk("l1_before_apply", l1_of(u), exp_l1[u]);
      tick();
      exp_l1[u] = v.l1;
      chk("drain_after_apply", drain_req[u], 0);
    end
    for (int k = 0; k < NU; k++) begin
      chk("l1_sets", l1_of(k), exp_l1[k]);
      chk("smem_sets", smem_of(k), TS - exp_l1[k]);
    end
    chk("busy_idle", cfg_busy, 0);
    chk("err_clear", cfg_err, 0);
  endtask

  // One randomized cycle: invariants, responder, optional DCR write.
  task automatic step_random(input bit allow_wr);
    int cur, idx, r;
    logic [31:0] d;
    logic [11:0] a;
    dcr_wr_valid = 1'b0;
    for (int u = 0; u < NU; u++) begin
      cur = l1_of(u);
      chk("sum_sets", cur + smem_of(u), TS);
      if (flush_req[u]) chk("drain_with_flush", drain_req[u], 1);
      if (cur != prev_l1[u]) begin
        chk("apply_drops_drain", drain_req[u], 0);
        if (cur < prev_l1[u]) begin
          chk("shrink_flushed_lo", dlo[u], cur);
          chk("shrink_flushed_hi", dhi[u], prev_l1[u]);
        end
      end
      prev_l1[u]    = cur;
      drain_ack[u]  = drain_req[u] && !flush_req[u] && ($urandom_range(0, 3) == 0);
      flush_done[u] = flush_req[u] && ($urandom_range(0, 2) == 0);
      if (flush_done[u]) begin
        dlo[u] = lo_of(u);
        dhi[u] = hi_of(u);
      end
    end
    if (allow_wr && $urandom_range(0, 9) == 0) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) d = 32'($urandom_range(0, 70));
      else if (r < 9) d = $urandom;
      else d = 32'(TS);
      case ($urandom_range(0, 3))
        0: a = BASE;
        1: a = BASE + 12'd1;
        2: a = BASE + 12'd2;
        default: a = 12'($urandom_range(0, 4095));
      endcase
      dcr_wr_valid = 1'b1;
      dcr_wr_addr  = a;
      dcr_wr_data  = d;
      idx = int'(a) - int'(BASE);
      if (idx >= 0 && idx < NU) exp_l1[idx] = model_l1(d);
    end
    tick();
  endtask

  initial begin
    int n;
    bit quiet;
    reset        = 1'b0;
    dcr_wr_valid = 1'b0;
    dcr_wr_addr  = '0;
    dcr_wr_data  = '0;
    drain_ack    = '0;
    flush_done   = '0;
    for (int k = 0; k < NU; k++) exp_l1[k] = TS;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int k = 0; k < NU; k++) begin
      chk("rst_l1", l1_of(k), TS);
      chk("rst_smem", smem_of(k), 0);
      chk("rst_lo", lo_of(k), 0);
      chk("rst_hi", hi_of(k), 0);
    end
    chk("rst_drain", drain_req, 0);
    chk("rst_flush", flush_req, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_err", cfg_err, 0);

    //             addr          data           u  chg fl lo  hi  l1
    vecs.push_back('{BASE,        32'd16,        0, 1, 1, 48, 64, 48});
    vecs.push_back('{BASE,        32'd0,         0, 1, 0, 0,  0,  64});
    vecs.push_back('{BASE,        32'd200,       0, 1, 1, 1,  64, 1});
    vecs.push_back('{BASE,        32'd63,        0, 0, 0, 0,  0,  1});
    vecs.push_back('{BASE,        32'd62,        0, 1, 0, 0,  0,  2});
    vecs.push_back('{BASE,        32'h0000_0FFF, 0, 1, 1, 1,  2,  1});
    vecs.push_back('{12'h00C,     32'd5,         0, 0, 0, 0,  0,  1});
    vecs.push_back('{12'h009,     32'd5,         0, 0, 0, 0,  0,  1});
    vecs.push_back('{BASE+12'd1,  32'd8,         1, 1, 1, 56, 64, 56});
    vecs.push_back('{BASE,        32'd0,         0, 1, 0, 0,  0,  64});
    vecs.push_back('{BASE+12'd1,  32'h1000_0000, 1, 1, 0, 0,  0,  64});
    foreach (vecs[i]) run_vec(vecs[i]);

    // Write during FLUSH: first apply uses the snapshot, then the unit re-drains.
    dcr_write(BASE, 32'd16);
    tick();
    pulse_ack(0);
    chk("wf_flush", flush_req[0], 1);
    dcr_write(BASE, 32'd32);
    chk("wf_lo_snap", lo_of(0), 48);
    chk("wf_hi_snap", hi_of(0), 64);
    pulse_done(0);
    chk("wf_apply", flush_req[0], 0);
    tick();
    chk("wf_l1_first", l1_of(0), 48);
    chk("wf_drain_gap", drain_req[0], 0);
    chk("wf_busy", cfg_busy, 1);
    tick();
    chk("wf_redrain", drain_req[0], 1);
    pulse_ack(0);
    chk("wf_flush2", flush_req[0], 1);
    chk("wf_lo2", lo_of(0), 32);
    chk("wf_hi2", hi_of(0), 48);
    pulse_done(0);
    tick();
    chk("wf_l1_final", l1_of(0), 32);
    chk("wf_smem_final", smem_of(0), 32);
    chk("wf_busy_done", cfg_busy, 0);

    // Write coincident with drain_ack: the exit decision uses the earlier pending value.
    dcr_write(BASE, 32'd48);
    tick();
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = BASE;
    dcr_wr_data  = 32'd0;
    drain_ack[0] = 1'b1;
    tick();
    dcr_wr_valid = 1'b0;
    drain_ack[0] = 1'b0;
    chk("wa_flush", flush_req[0], 1);
    chk("wa_lo", lo_of(0), 16);
    chk("wa_hi", hi_of(0), 32);
    pulse_done(0);
    tick();
    chk("wa_l1_first", l1_of(0), 16);
    tick();
    chk("wa_redrain", drain_req[0], 1);
    pulse_ack(0);
    chk("wa_grow_no_flush", flush_req[0], 0);
    tick();
    chk("wa_l1_final", l1_of(0), 64);
    exp_l1[0] = 64;

    // Drain timeout on unit 1.
    dcr_write(BASE + 12'd1, 32'd16);
    n = 0;
    while (drain_req[1] && n < TO + 100) begin
      tick();
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_err", cfg_err[1], 1);
    chk("to_drain", drain_req[1], 0);
    chk("to_l1", l1_of(1), 64);
    chk("to_busy", cfg_busy, 0);
    tick();
    chk("to_no_retry", drain_req[1], 0);
    dcr_write(BASE + 12'd1, 32'd0);
    chk("to_err_clear", cfg_err[1], 0);
    chk("to_no_drain", drain_req[1], 0);

    // Asynchronous reset while flushing.
    dcr_write(BASE, 32'd16);
    tick();
    pulse_ack(0);
    chk("ar_in_flush", flush_req[0], 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_flush", flush_req, 0);
    chk("ar_drain", drain_req, 0);
    chk("ar_lo", lo_of(0), 0);
    chk("ar_hi", hi_of(0), 0);
    chk("ar_l1", l1_of(0), 64);
    chk("ar_busy", cfg_busy, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    chk("ar_stays_idle", drain_req, 0);

    // Randomized traffic with an always-cooperating unit responder.
    for (int k = 0; k < NU; k++) begin
      exp_l1[k]  = TS;
      prev_l1[k] = l1_of(k);
      dlo[k]     = -1;
      dhi[k]     = -1;
    end
    repeat (4000) step_random(1'b1);
    quiet = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!cfg_busy && drain_req == '0) begin
        quiet = 1'b1;
        break;
      end
      step_random(1'b0);
    end
    chk("rand_quiesce", quiet, 1);
    for (int k = 0; k < NU; k++) begin
      chk("rand_l1", l1_of(k), exp_l1[k]);
      chk("rand_smem", smem_of(k), TS - exp_l1[k]);
    end
    chk("rand_flush_idle", flush_req, 0);
    chk("rand_err", cfg_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
